// File: rtl/threshold_pipelined.sv
// Adaptive binarisation: streams image and threshold memories, writes one PIXEL_BITS result per pixel.
// Address issued in cycle k is written in cycle k+READ_LATENCY+1; the source memories have no backpressure.
module threshold_pipelined #(
    parameter int WIDTH_BITS   = 8,
    parameter int HEIGHT_BITS  = 8,
    parameter int WIDTH        = 2**WIDTH_BITS,
    parameter int HEIGHT       = 2**HEIGHT_BITS,
    parameter int PIXEL_BITS   = 8,
    parameter int C_BITS       = 5,
    parameter int READ_LATENCY = 1,
    parameter int STATE_CODE   = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [2:0]                        global_state,
    input  logic [1:0]                        mode,
    input  logic [C_BITS-1:0]                 C,
    output logic [WIDTH_BITS-1:0]             oImageCol,
    output logic [HEIGHT_BITS-1:0]            oImageRow,
    input  logic [PIXEL_BITS-1:0]             iImageData,
    output logic [WIDTH_BITS-1:0]             oThresholdCol,
    output logic [HEIGHT_BITS-1:0]            oThresholdRow,
    input  logic [PIXEL_BITS-1:0]             iThresholdData,
    output logic [WIDTH_BITS-1:0]             oResultCol,
    output logic [HEIGHT_BITS-1:0]            oResultRow,
    output logic [PIXEL_BITS-1:0]             oResultData,
    output logic                              oResultWren,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]   oWhiteCount,
    output logic                              finished
);
    localparam int AW = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [AW-1:0]           pos;
    logic [AW-1:0]           wr_addr;
    logic [1:0]              mode_q;
    logic [C_BITS-1:0]       c_q;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [AW-1:0]           addr_pipe [READ_LATENCY];

    logic                    run_en;
    logic [PIXEL_BITS:0]     t_wide;
    logic [PIXEL_BITS-1:0]   t_sat;
    logic                    gt;
    logic [PIXEL_BITS-1:0]   res;

    assign run_en        = (global_state == 3'(STATE_CODE));
    assign oImageCol     = pos[WIDTH_BITS-1:0];
    assign oImageRow     = pos[AW-1:WIDTH_BITS];
    assign oThresholdCol = pos[WIDTH_BITS-1:0];
    assign oThresholdRow = pos[AW-1:WIDTH_BITS];
    assign oResultCol    = wr_addr[WIDTH_BITS-1:0];
    assign oResultRow    = wr_addr[AW-1:WIDTH_BITS];

    // One extra bit catches the borrow so the offset clamps at zero instead of wrapping.
    always_comb begin
        t_wide = {1'b0, iThresholdData} - {{(PIXEL_BITS+1-C_BITS){1'b0}}, c_q};
        t_sat  = t_wide[PIXEL_BITS] ? '0 : t_wide[PIXEL_BITS-1:0];
        gt     = iImageData > t_sat;
        res    = '0;
        case (mode_q)
            2'd0:    res = gt ? '1 : '0;
            2'd1:    res = gt ? '0 : '1;
            2'd2:    res = gt ? iImageData : '0;
            default: res = gt ? t_sat : iImageData;
        endcase
    end

    // Address side of the delay line carries no state worth resetting; validity is tracked in vld_pipe.
    always_ff @(posedge clock) begin
        addr_pipe[0] <= pos;
        for (int i = 1; i < READ_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pos         <= '0;
            wr_addr     <= '0;
            mode_q      <= '0;
            c_q         <= '0;
            vld_pipe    <= '0;
            oResultData <= '0;
            oResultWren <= 1'b0;
            oWhiteCount <= '0;
            finished    <= 1'b0;
        end else begin
            vld_pipe[0] <= (state == RUN);
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];

            oResultWren <= vld_pipe[READ_LATENCY-1];
            if (vld_pipe[READ_LATENCY-1]) begin
                wr_addr     <= addr_pipe[READ_LATENCY-1];
                oResultData <= res;
                if (gt) oWhiteCount <= oWhiteCount + (AW+1)'(1);
            end

            case (state)
                IDLE: begin
                    pos      <= '0;
                    finished <= 1'b0;
                    if (run_en) begin
                        mode_q      <= mode;
                        c_q         <= C;
                        oWhiteCount <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (pos == LAST) state <= DRAIN;
                    else             pos   <= pos + AW'(1);
                end
                // Pipe empties in the same cycle the final write is on the bus.
                DRAIN: begin
                    if (vld_pipe == '0) begin
                        state    <= DONE;
                        finished <= 1'b1;
                    end
                end
                default: begin
                    if (!run_en) begin
                        state    <= IDLE;
                        finished <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
